// File: rtl/temp_scan_scheduler.sv
// Temperature sensor scan scheduler.
// Periodically (or on request) reads a 16-bit word from up to three SPI-style
// temperature sensors sharing one serial clock and data line. Each sensor has
// its own active-low chip select. Sensors are visited in order 1, 2, 3, and
// sensors whose enable bit is clear are skipped.
module temp_scan_scheduler #(
   parameter int unsigned SCK_HALF    = 4,
   parameter int unsigned CS_SETUP    = 4,
   parameter int unsigned SCAN_PERIOD = 800000
) (
   input  logic        fab_clk_8MHz,
   input  logic        rst,
   input  logic        en,
   input  logic        start,
   input  logic [2:0]  sensor_en,
   input  logic        temp_so,
   output logic        temp_sck,
   output logic        temp1_csn,
   output logic        temp2_csn,
   output logic        temp3_csn,
   output logic [15:0] temp1,
   output logic [15:0] temp2,
   output logic [15:0] temp3,
   output logic [2:0]  temp_valid,
   output logic        busy,
   output logic        scan_done,
   output logic [31:0] temp_count
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      STORE = 3'd4,
      GAP   = 3'd5
   } state_t;

   localparam logic [7:0]  CS_LAST     = 8'(CS_SETUP - 1);
   localparam logic [7:0]  SCK_LAST    = 8'(SCK_HALF - 1);
   localparam logic [31:0] PERIOD_LAST = 32'(SCAN_PERIOD - 1);
   localparam logic [4:0]  HALF_LAST   = 5'd31;
   // Sensor index meaning "no sensor selected" (empty scan).
   localparam logic [1:0]  SEL_NONE    = 2'd3;

   state_t      state, state_n;
   logic [1:0]  sel, sel_n;
   logic [7:0]  tmr, tmr_n;
   logic [4:0]  hcnt, hcnt_n;
   logic        sck_n;
   logic [15:0] shreg, shreg_n;
   logic [31:0] period, period_n;
   logic        store_n;
   logic        done_n;
   logic        cs_active_n;
   logic [1:0]  first_sel;
   logic [1:0]  next_sel;

   // Lowest-numbered enabled sensor in the mask, or SEL_NONE.
   function automatic logic [1:0] first_set(input logic [2:0] mask);
      logic [1:0] idx;
      if (mask[0])      idx = 2'd0;
      else if (mask[1]) idx = 2'd1;
      else if (mask[2]) idx = 2'd2;
      else              idx = SEL_NONE;
      return idx;
   endfunction

   // Sensors still to be visited after the given one.
   function automatic logic [2:0] remaining_after(input logic [1:0] idx);
      logic [2:0] mask;
      case (idx)
         2'd0:    mask = 3'b110;
         2'd1:    mask = 3'b100;
         default: mask = 3'b000;
      endcase
      return mask;
   endfunction

   assign first_sel = first_set(sensor_en);
   assign next_sel  = first_set(sensor_en & remaining_after(sel));

   // Next-state, timer, serial clock and shift-register logic.
   always_comb begin
      state_n  = state;
      sel_n    = sel;
      tmr_n    = tmr;
      hcnt_n   = hcnt;
      sck_n    = temp_sck;
      shreg_n  = shreg;
      period_n = period;
      store_n  = 1'b0;
      done_n   = 1'b0;
      case (state)
         IDLE: begin
            if (start || (en && (period == PERIOD_LAST))) begin
               period_n = 32'd0;
               tmr_n    = 8'd0;
               sel_n    = first_sel;
               // An empty mask goes straight to STORE, which then ends the scan
               // without touching any sensor.
               state_n  = (first_sel == SEL_NONE) ? STORE : SETUP;
            end else if (en) begin
               period_n = period + 32'd1;
            end
         end
         SETUP: begin
            if (tmr == CS_LAST) begin
               tmr_n   = 8'd0;
               hcnt_n  = 5'd0;
               state_n = SHIFT;
            end else begin
               tmr_n = tmr + 8'd1;
            end
         end
         SHIFT: begin
            if (tmr == SCK_LAST) begin
               tmr_n = 8'd0;
               sck_n = ~temp_sck;
               // Sample on the low-to-high transition of the serial clock.
               if (!temp_sck)
                  shreg_n = {shreg[14:0], temp_so};
               if (hcnt == HALF_LAST)
                  state_n = HOLD;
               else
                  hcnt_n = hcnt + 5'd1;
            end else begin
               tmr_n = tmr + 8'd1;
            end
         end
         HOLD: begin
            if (tmr == CS_LAST) begin
               tmr_n   = 8'd0;
               store_n = 1'b1;
               state_n = STORE;
            end else begin
               tmr_n = tmr + 8'd1;
            end
         end
         STORE: begin
            tmr_n = 8'd0;
            if (next_sel == SEL_NONE) begin
               done_n  = 1'b1;
               state_n = IDLE;
            end else begin
               sel_n   = next_sel;
               state_n = GAP;
            end
         end
         GAP: begin
            if (tmr == CS_LAST) begin
               tmr_n   = 8'd0;
               state_n = SETUP;
            end else begin
               tmr_n = tmr + 8'd1;
            end
         end
         default: state_n = IDLE;
      endcase
      cs_active_n = (state_n == SETUP) || (state_n == SHIFT) || (state_n == HOLD);
   end

   // FSM state, timers, serial clock and shift register.
   always_ff @(posedge fab_clk_8MHz or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         sel      <= SEL_NONE;
         tmr      <= 8'd0;
         hcnt     <= 5'd0;
         temp_sck <= 1'b0;
         shreg    <= 16'd0;
         period   <= 32'd0;
      end else begin
         state    <= state_n;
         sel      <= sel_n;
         tmr      <= tmr_n;
         hcnt     <= hcnt_n;
         temp_sck <= sck_n;
         shreg    <= shreg_n;
         period   <= period_n;
      end
   end

   // Registered outputs decoded from the next state so they align with it.
   always_ff @(posedge fab_clk_8MHz or posedge rst) begin
      if (rst) begin
         temp1_csn  <= 1'b1;
         temp2_csn  <= 1'b1;
         temp3_csn  <= 1'b1;
         temp1      <= 16'd0;
         temp2      <= 16'd0;
         temp3      <= 16'd0;
         temp_valid <= 3'b000;
         busy       <= 1'b0;
         scan_done  <= 1'b0;
         temp_count <= 32'd0;
      end else begin
         temp1_csn  <= ~(cs_active_n && (sel_n == 2'd0));
         temp2_csn  <= ~(cs_active_n && (sel_n == 2'd1));
         temp3_csn  <= ~(cs_active_n && (sel_n == 2'd2));
         busy       <= (state_n != IDLE);
         scan_done  <= done_n;
         temp_valid <= 3'b000;
         if (done_n)
            temp_count <= temp_count + 32'd1;
         if (store_n) begin
            case (sel)
               2'd0: begin
                  temp1      <= shreg;
                  temp_valid <= 3'b001;
               end
               2'd1: begin
                  temp2      <= shreg;
                  temp_valid <= 3'b010;
               end
               2'd2: begin
                  temp3      <= shreg;
                  temp_valid <= 3'b100;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
